// File: rtl/rule_aggregator_if.sv
// Rule-beat stream into the aggregator: firing strength, singleton output,
// last marker, and a valid/ready handshake.
`timescale 1ns/1ps
interface rule_aggregator_if;
  logic        valid;
  logic        ready;
  logic [15:0] w;
  logic [15:0] g;
  logic        last;

  modport master (output valid, output w, output g, output last, input ready);
  modport slave  (input valid, input w, input g, input last, output ready);
endinterface

// File: rtl/rule_aggregator.sv
// Accumulates S_w = sum(w) and S_wg = sum(w*g) over one inference, then
// right-shifts both sums by the same amount until S_w fits Q1.15.
//
// state | meaning
// IDLE  | waiting for start after reset
// ACCUM | accepting rule beats, multiply stage and accumulate stage running
// FLUSH | folding the last pending product into the accumulators
// NORM  | block-normalising until acc_w <= 0x7FFF, then publishing
// DONE  | results held, waiting for the next start
`timescale 1ns/1ps
module rule_aggregator #(
  parameter int N_RULES = 9,
  parameter int ACC_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  rule_aggregator_if.slave   rule,
  output logic [15:0]        S_w,
  output logic [15:0]        S_wg,
  output logic               out_valid,
  output logic               err_cnt
);

  localparam int CNT_W = $clog2(N_RULES + 1);

  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, NORM, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc_w;
  logic [ACC_W-1:0]   acc_wg;
  logic [15:0]        prod_r;
  logic [15:0]        w_r;
  logic               pv;
  logic [CNT_W-1:0]   cnt;
  logic               ready_r;

  logic [15:0]        wc;
  logic [15:0]        gc;
  logic [31:0]        full_prod;
  logic [15:0]        prod_next;

  // Clamp inputs to 1.0 and form the rounded Q1.15 product; result is at most 0x8000.
  always_comb begin
    wc        = (rule.w > 16'h8000) ? 16'h8000 : rule.w;
    gc        = (rule.g > 16'h8000) ? 16'h8000 : rule.g;
    full_prod = {16'h0000, wc} * {16'h0000, gc};
    prod_next = 16'((full_prod + 32'd16384) >> 15);
  end

  assign rule.ready = ready_r;

  // Sequencer plus two-stage multiply/accumulate datapath and normalisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_w     <= '0;
      acc_wg    <= '0;
      prod_r    <= '0;
      w_r       <= '0;
      pv        <= 1'b0;
      cnt       <= '0;
      ready_r   <= 1'b0;
      S_w       <= '0;
      S_wg      <= '0;
      out_valid <= 1'b0;
      err_cnt   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      pv        <= 1'b0;
      if (pv) begin
        acc_w  <= acc_w + ACC_W'(w_r);
        acc_wg <= acc_wg + ACC_W'(prod_r);
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= ACCUM;
            acc_w   <= '0;
            acc_wg  <= '0;
            cnt     <= '0;
            err_cnt <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        ACCUM: begin
          if (rule.valid) begin
            prod_r <= prod_next;
            w_r    <= wc;
            pv     <= 1'b1;
            cnt    <= cnt + CNT_W'(1);
            if (rule.last) begin
              state   <= FLUSH;
              ready_r <= 1'b0;
            end else if (cnt == CNT_W'(N_RULES - 1)) begin
              // Rule budget exhausted without a last marker: close the inference anyway.
              err_cnt <= 1'b1;
              state   <= FLUSH;
              ready_r <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state <= NORM;
        end
        NORM: begin
          if (acc_w > ACC_W'(16'h7FFF)) begin
            acc_w  <= acc_w >> 1;
            acc_wg <= acc_wg >> 1;
          end else begin
            S_w       <= acc_w[15:0];
            S_wg      <= acc_wg[15:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rule_aggregator.sv
// Scoreboard bench for rule_aggregator: directed cases then random inferences,
// expected sums computed from clamped/rounded arithmetic in the bench.
`timescale 1ns/1ps
module tb_rule_aggregator;
  localparam int N_RULES = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] S_w;
  logic [15:0] S_wg;
  logic        out_valid;
  logic        err_cnt;

  rule_aggregator_if rif();

  rule_aggregator #(.N_RULES(N_RULES), .ACC_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rule(rif),
    .S_w(S_w), .S_wg(S_wg), .out_valid(out_valid), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sw;
    int swg;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   w_arr[N_RULES];
  int   g_arr[N_RULES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got S_w=0x%0h S_wg=0x%0h with nothing pending", S_w, S_wg);
      end else begin
        mon_e = sb.pop_front();
        chk("S_w", int'(S_w), mon_e.sw);
        chk("S_wg", int'(S_wg), mon_e.swg);
        chk("err_cnt", int'(err_cnt), mon_e.err);
        chk("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Reference: clamp, rounded product, sum, halve both until S_w fits 0x7FFF.
  function automatic exp_t model(input int n, input int err, input int last_cyc);
    exp_t e;
    longint sw = 0;
    longint swg = 0;
    int k = 0;
    for (int i = 0; i < n; i++) begin
      longint wc = (w_arr[i] > 32768) ? 32768 : w_arr[i];
      longint gc = (g_arr[i] > 32768) ? 32768 : g_arr[i];
      sw  += wc;
      swg += (wc * gc + 16384) / 32768;
    end
    while (sw > 32767) begin
      sw  = sw / 2;
      swg = swg / 2;
      k++;
    end
    e.sw  = int'(sw);
    e.swg = int'(swg);
    e.err = err;
    e.cyc = last_cyc + 2 + k;
    return e;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input int w, input int g, input bit last, output int acc_cyc);
    bit a;
    @(negedge clk);
    rif.valid = 1'b1;
    rif.w     = 16'(w);
    rif.g     = 16'(g);
    rif.last  = last;
    acc_cyc   = -1;
    for (int t = 0; t < 20; t++) begin
      a = rif.ready;
      @(posedge clk);
      #1;
      if (a) begin
        acc_cyc = cyc;
        return;
      end
      @(negedge clk);
    end
    chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_inf(input int n, input bit use_last, input bit gaps, input bit mid_start);
    int acc_cyc = 0;
    pulse_start();
    chk("err_cleared_by_start", int'(err_cnt), 0);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (mid_start && i == 2) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_beat(w_arr[i], g_arr[i], use_last && (i == n - 1), acc_cyc);
      if (gaps || mid_start) rif.valid = 1'b0;
    end
    rif.valid = 1'b0;
    rif.last  = 1'b0;
    sb.push_back(model(n, use_last ? 0 : 1, acc_cyc));
    if (!use_last) begin
      chk("ready_low_after_budget", int'(rif.ready), 0);
      chk("err_set_at_budget", int'(err_cnt), 1);
    end
    wait_empty();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ul;
    int dummy;
    rif.valid = 1'b0;
    rif.w     = '0;
    rif.g     = '0;
    rif.last  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_S_w", int'(S_w), 0);
    chk("rst_S_wg", int'(S_wg), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_ready", int'(rif.ready), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single beat.
    w_arr[0] = 'h4000; g_arr[0] = 'h6000;
    run_inf(1, 1'b1, 1'b0, 1'b0);

    // Two normalisation shifts.
    w_arr[0] = 'h8000; g_arr[0] = 'h8000;
    w_arr[1] = 'h8000; g_arr[1] = 'h4000;
    w_arr[2] = 'h8000; g_arr[2] = 'h0000;
    run_inf(3, 1'b1, 1'b0, 1'b0);

    // Clamp of w above 1.0 and rounding of the full-scale product.
    w_arr[0] = 'hFFFF; g_arr[0] = 'h8000;
    run_inf(1, 1'b1, 1'b0, 1'b0);

    // Gaps and a start pulse in the middle of accumulation.
    for (int i = 0; i < 4; i++) begin w_arr[i] = 'h1000; g_arr[i] = 'h4000; end
    run_inf(4, 1'b1, 1'b1, 1'b1);

    // Rule budget exhausted without last.
    for (int i = 0; i < N_RULES; i++) begin w_arr[i] = 'h0800; g_arr[i] = 'h8000; end
    run_inf(N_RULES, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of accumulation aborts the inference.
    w_arr[0] = 'h2000; g_arr[0] = 'h2000;
    w_arr[1] = 'h3000; g_arr[1] = 'h7000;
    pulse_start();
    send_beat(w_arr[0], g_arr[0], 1'b0, dummy);
    send_beat(w_arr[1], g_arr[1], 1'b0, dummy);
    @(negedge clk);
    rst_n = 1'b0;
    rif.valid = 1'b0;
    #1;
    chk("midrst_S_w", int'(S_w), 0);
    chk("midrst_S_wg", int'(S_wg), 0);
    chk("midrst_err_cnt", int'(err_cnt), 0);
    chk("midrst_ready", int'(rif.ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    w_arr[0] = 'h4000; g_arr[0] = 'h6000;
    w_arr[1] = 'h7000; g_arr[1] = 'h1234;
    run_inf(2, 1'b1, 1'b0, 1'b0);

    // Random inferences.
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, N_RULES);
      for (int i = 0; i < n; i++) begin
        w_arr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 'hFFFF) : $urandom_range(0, 'h8000);
        g_arr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 'hFFFF) : $urandom_range(0, 'h8000);
      end
      ul = (n == N_RULES) ? 1'($urandom_range(0, 1)) : 1'b1;
      run_inf(n, ul, 1'($urandom_range(0, 1)), (n >= 3) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
